// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the basic FIFO read port.
package fifo_pkg;
   localparam int RD_LAT_MAX   = 4;
   localparam int CREDIT_SLACK = 2;
   localparam int INFL_W       = $clog2(RD_LAT_MAX + 1);
   localparam int CNT_W        = 4;

   function automatic logic [INFL_W-1:0] popcount(input logic [RD_LAT_MAX-1:0] v);
      popcount = '0;
      for (int i = 0; i < RD_LAT_MAX; i++)
         popcount += INFL_W'(v[i]);
   endfunction
endpackage

// File: rtl/fifo_rd_buf.sv
// Ring-buffer skid stage holding words that landed from storage until the sink takes them.
module fifo_rd_buf
   import fifo_pkg::*;
#(
   parameter int DAT_WID = 32,
   parameter int BUF_DEP = 3,
   localparam int OCC_W  = $clog2(BUF_DEP + 1),
   localparam int PTR_W  = $clog2(BUF_DEP)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [DAT_WID-1:0] i_push_dat,
   input  logic               i_pop,
   output logic [OCC_W-1:0]   o_occ,
   output logic [DAT_WID-1:0] o_dat
);
   logic [DAT_WID-1:0] r_mem [BUF_DEP];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [OCC_W-1:0]   r_occ;

   // Contents are intentionally left unreset; occ alone qualifies them.
   always_ff @(posedge clk) begin
      if (i_push)
         r_mem[r_wr_ptr] <= i_push_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (i_push)
            r_wr_ptr <= (r_wr_ptr == PTR_W'(BUF_DEP - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (i_pop)
            r_rd_ptr <= (r_rd_ptr == PTR_W'(BUF_DEP - 1)) ? '0 : r_rd_ptr + 1'b1;
         if (i_push && !i_pop)
            r_occ <= r_occ + 1'b1;
         else if (!i_push && i_pop)
            r_occ <= r_occ - 1'b1;
      end
   end

   assign o_occ = r_occ;
   assign o_dat = r_mem[r_rd_ptr];
endmodule

// File: rtl/basic_fifo_rd_port.sv
// FIFO consumer port: credit-based oen issue, read-latency pipe, and valid/ready output.
module basic_fifo_rd_port
   import fifo_pkg::*;
#(
   parameter int DAT_WID = 32,
   parameter int RD_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fifo_empty,
   output logic               fifo_oen,
   input  logic [DAT_WID-1:0] fifo_rdata,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [DAT_WID-1:0] out_dat,
   output logic               busy
);
   localparam int BUF_DEP = RD_LAT + CREDIT_SLACK;
   localparam int OCC_W   = $clog2(BUF_DEP + 1);

   logic [RD_LAT-1:0] r_pipe;
   logic [OCC_W-1:0]  w_occ;
   logic [INFL_W-1:0] w_infl;
   logic [CNT_W-1:0]  w_used;
   logic              w_push;
   logic              w_pop;

   assign w_infl = popcount(RD_LAT_MAX'(r_pipe));
   assign w_used = CNT_W'(w_occ) + CNT_W'(w_infl);

   // Credit counts only registered state, so out_rdy never reaches fifo_oen.
   assign fifo_oen = ~rst & ~fifo_empty & (w_used < CNT_W'(BUF_DEP));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= fifo_oen;
         for (int i = 1; i < RD_LAT; i++)
            r_pipe[i] <= r_pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         assert (w_used <= CNT_W'(BUF_DEP));
   end

   assign w_push  = r_pipe[RD_LAT-1] & ~rst;
   assign out_vld = (w_occ != '0);
   assign w_pop   = out_vld & out_rdy;
   assign busy    = (w_occ != '0) | (w_infl != '0);

   fifo_rd_buf #(
      .DAT_WID (DAT_WID),
      .BUF_DEP (BUF_DEP)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_push_dat (fifo_rdata),
      .i_pop      (w_pop),
      .o_occ      (w_occ),
      .o_dat      (out_dat)
   );
endmodule

// File: tb/tb_basic_fifo_rd_port.sv
// Directed bench: two ports (RD_LAT=1 and RD_LAT=2) fed by behavioural FIFO/storage models.
module tb_basic_fifo_rd_port;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] src1 [64];
   logic [31:0] src2 [64];
   int idx1 = 0, idx2 = 0;
   int n1 = 0, n2 = 0;

   logic        empty1, oen1, vld1, rdy1, busy1;
   logic        empty2, oen2, vld2, rdy2, busy2;
   logic [31:0] rd1, dat1, rd2, dat2, p2;

   int n_checks = 0;
   int n_fail   = 0;

   assign empty1 = (idx1 >= n1);
   assign empty2 = (idx2 >= n2);

   // Storage model: oen pops a word, data appears RD_LAT cycles later.
   always @(posedge clk) begin
      if (oen1) begin
         rd1  <= src1[idx1 % 64];
         idx1 <= idx1 + 1;
      end
      if (oen2) begin
         p2   <= src2[idx2 % 64];
         idx2 <= idx2 + 1;
      end
      rd2 <= p2;
   end

   basic_fifo_rd_port #(.DAT_WID(32), .RD_LAT(1)) u1 (
      .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_oen(oen1), .fifo_rdata(rd1),
      .out_vld(vld1), .out_rdy(rdy1), .out_dat(dat1), .busy(busy1));

   basic_fifo_rd_port #(.DAT_WID(32), .RD_LAT(2)) u2 (
      .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_oen(oen2), .fifo_rdata(rd2),
      .out_vld(vld2), .out_rdy(rdy2), .out_dat(dat2), .busy(busy2));

   task automatic test_reset();
      rst = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
      n1 = idx1 + 5; n2 = idx2 + 5;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (oen1 !== 1'b0 || oen2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_oen cyc %0d got %b/%b exp 0/0", c, oen1, oen2);
         end
         n_checks++;
         if (vld1 !== 1'b0 || vld2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_vld cyc %0d got %b/%b exp 0/0", c, vld1, vld2);
         end
         n_checks++;
         if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy cyc %0d got %b/%b exp 0/0", c, busy1, busy2);
         end
      end
      n1 = idx1; n2 = idx2;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      @(negedge clk);
      rdy1 = 1'b1;
      src1[idx1 % 64] = 32'hA5A5_0001;
      n1 = idx1 + 1;
      #1;
      n_checks++;
      if (oen1 !== 1'b1) begin n_fail++; $display("FAIL single_oen_t got %b exp 1", oen1); end
      @(negedge clk);
      n_checks++;
      if (oen1 !== 1'b0 || vld1 !== 1'b0 || busy1 !== 1'b1) begin
         n_fail++; $display("FAIL single_t1 oen/vld/busy got %b%b%b exp 001", oen1, vld1, busy1);
      end
      @(negedge clk);
      n_checks++;
      if (vld1 !== 1'b1 || dat1 !== 32'hA5A5_0001) begin
         n_fail++; $display("FAIL single_t2 vld/dat got %b/%h exp 1/a5a50001", vld1, dat1);
      end
      @(negedge clk);
      n_checks++;
      if (vld1 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL single_t3 vld/busy got %b/%b exp 0/0", vld1, busy1);
      end
   endtask

   task automatic test_stream();
      int got = 0, first = -1;
      @(negedge clk);
      rdy2 = 1'b1;
      for (int k = 0; k < 16; k++) src2[(idx2 + k) % 64] = k;
      n2 = idx2 + 16;
      #1;
      n_checks++;
      if (oen2 !== 1'b1) begin n_fail++; $display("FAIL stream_oen got %b exp 1", oen2); end
      for (int c = 1; c < 60 && got < 16; c++) begin
         @(negedge clk);
         if (vld2) begin
            if (first < 0) first = c;
            n_checks++;
            if (dat2 !== 32'(got)) begin
               n_fail++; $display("FAIL stream_dat got %h exp %h", dat2, got);
            end
            got++;
         end else if (got > 0) begin
            n_checks++; n_fail++;
            $display("FAIL stream_gap at cyc %0d got vld 0 exp 1", c);
         end
      end
      n_checks++;
      if (first != 3) begin n_fail++; $display("FAIL stream_latency got %0d exp 3", first); end
      n_checks++;
      if (got != 16) begin n_fail++; $display("FAIL stream_count got %0d exp 16", got); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int pulses = 0, got = 0;
      @(negedge clk);
      rdy1 = 1'b0;
      for (int k = 0; k < 8; k++) src1[(idx1 + k) % 64] = 32'h100 + k;
      n1 = idx1 + 8;
      #1;
      for (int c = 0; c < 10; c++) begin
         if (oen1) pulses++;
         if (vld1) begin
            n_checks++;
            if (dat1 !== 32'h100) begin
               n_fail++; $display("FAIL bp_frozen cyc %0d got %h exp 00000100", c, dat1);
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (pulses != 3) begin n_fail++; $display("FAIL bp_pulses got %0d exp 3", pulses); end
      n_checks++;
      if (oen1 !== 1'b0 || vld1 !== 1'b1) begin
         n_fail++; $display("FAIL bp_hold oen/vld got %b/%b exp 0/1", oen1, vld1);
      end
      rdy1 = 1'b1;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (vld1) begin
            n_checks++;
            if (dat1 !== 32'h100 + 32'(got)) begin
               n_fail++; $display("FAIL bp_order got %h exp %h", dat1, 32'h100 + got);
            end
            got++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (got != 8) begin n_fail++; $display("FAIL bp_count got %0d exp 8", got); end
   endtask

   task automatic test_wrap();
      int got = 0;
      @(negedge clk);
      for (int k = 0; k < 20; k++) src2[(idx2 + k) % 64] = 32'h200 + k;
      n2 = idx2 + 20;
      for (int c = 0; c < 200 && got < 20; c++) begin
         rdy2 = (c % 4 == 0) || (c % 4 == 3);
         if (vld2 && rdy2) begin
            n_checks++;
            if (dat2 !== 32'h200 + 32'(got)) begin
               n_fail++; $display("FAIL wrap_order got %h exp %h", dat2, 32'h200 + got);
            end
            got++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (got != 20) begin n_fail++; $display("FAIL wrap_count got %0d exp 20", got); end
      rdy2 = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (vld2 !== 1'b0 || busy2 !== 1'b0) begin
         n_fail++; $display("FAIL wrap_extra vld/busy got %b/%b exp 0/0", vld2, busy2);
      end
   endtask

   task automatic test_reset_mid();
      int got = 0;
      @(negedge clk);
      rdy1 = 1'b0;
      for (int k = 0; k < 6; k++) src1[(idx1 + k) % 64] = 32'h300 + k;
      n1 = idx1 + 6;
      repeat (3) @(negedge clk);
      n_checks++;
      if (vld1 !== 1'b1 || busy1 !== 1'b1) begin
         n_fail++; $display("FAIL rmid_pre vld/busy got %b/%b exp 1/1", vld1, busy1);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (oen1 !== 1'b0) begin n_fail++; $display("FAIL rmid_oen_in_rst got %b exp 0", oen1); end
      @(negedge clk);
      n_checks++;
      if (vld1 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL rmid_after vld/busy got %b/%b exp 0/0", vld1, busy1);
      end
      rst = 1'b0;
      rdy1 = 1'b1;
      for (int c = 0; c < 30 && got < 3; c++) begin
         @(negedge clk);
         if (vld1) begin
            n_checks++;
            if (dat1 !== 32'h303 + 32'(got)) begin
               n_fail++; $display("FAIL rmid_dat got %h exp %h", dat1, 32'h303 + got);
            end
            got++;
         end
      end
      n_checks++;
      if (got != 3) begin n_fail++; $display("FAIL rmid_count got %0d exp 3", got); end
      repeat (4) @(negedge clk);
      n_checks++;
      if (vld1 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL rmid_drain vld/busy got %b/%b exp 0/0", vld1, busy1);
      end
   endtask

   initial begin
      rdy1 = 1'b0; rdy2 = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
